y86_execute: RTL and testbench

Execute stage of the sequential Y86-64 processor, between decode and memory. Computes `valE` through a 64-bit ALU from the instruction code and operands, holds the Z/S/O condition-code register, and evaluates the branch/move condition `cnd` for `jXX` and `cmovXX`. The ALU datapath is combinational; only the condition codes are registered.

---
 rtl/y86_pkg.sv | 38 +++
 rtl/y86_alu.sv | 53 +++++
 rtl/y86_execute.sv | 135 +++++++++++++
 tb/tb_y86_execute.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: constants shared by the Y86-64 execute stage.
// Holds the instruction codes, the ALU function codes and the condition
// codes used by jXX / cmovXX, plus the reset value of the CC register.
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // ALU function codes (same encoding as OPq ifun)
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  // Condition codes (jXX / cmovXX ifun)
  localparam logic [3:0] C_ALWAYS = 4'h0;
  localparam logic [3:0] C_LE     = 4'h1;
  localparam logic [3:0] C_L      = 4'h2;
  localparam logic [3:0] C_E      = 4'h3;
  localparam logic [3:0] C_NE     = 4'h4;
  localparam logic [3:0] C_GE     = 4'h5;
  localparam logic [3:0] C_G      = 4'h6;

  // CC layout {OF,SF,ZF}; reset leaves only ZF set
  localparam logic [2:0] CC_RESET = 3'b001;

endpackage

// File: rtl/y86_alu.sv
// y86_alu: purely combinational 64-bit ALU of the execute stage.
// Ports:
//   aluA, aluB : operands; the result is always aluB <op> aluA
//   alufun     : ALU_ADD / ALU_SUB / ALU_AND / ALU_XOR (others give 0)
//   result     : 64-bit result, modulo 2^64
//   cc_new     : {OF,SF,ZF} derived from result for the selected function
module y86_alu
  import y86_pkg::*;
(
  input  logic [63:0] aluA,
  input  logic [63:0] aluB,
  input  logic [3:0]  alufun,
  output logic [63:0] result,
  output logic [2:0]  cc_new
);

  logic [63:0] res_s;
  logic        of_s;

  // Arithmetic/logic result and signed-overflow detection
  always_comb begin
    res_s = 64'd0;
    of_s  = 1'b0;
    case (alufun)
      ALU_ADD: begin
        res_s = aluB + aluA;
        // Same-sign operands producing the opposite sign overflowed
        of_s  = (aluA[63] == aluB[63]) && (res_s[63] != aluB[63]);
      end
      ALU_SUB: begin
        res_s = aluB - aluA;
        // Only mixed-sign subtraction can overflow; it did if the sign left aluB's
        of_s  = (aluA[63] != aluB[63]) && (res_s[63] != aluB[63]);
      end
      ALU_AND: begin
        res_s = aluB & aluA;
        of_s  = 1'b0;
      end
      ALU_XOR: begin
        res_s = aluB ^ aluA;
        of_s  = 1'b0;
      end
      default: begin
        res_s = 64'd0;
        of_s  = 1'b0;
      end
    endcase
  end

  assign result = res_s;
  assign cc_new = {of_s, res_s[63], (res_s == 64'd0)};

endmodule

// File: rtl/y86_execute.sv
// y86_execute: execute stage of the sequential Y86-64 processor.
// Ports:
//   clk, rst          : clock; asynchronous active-high reset of the CC register
//   icode, ifun       : instruction and function code
//   valA, valB, valC  : register operands and instruction constant
//   valE              : combinational ALU result
//   cnd               : combinational jXX/cmovXX condition (0 for other icodes)
//   flags             : CC register, [0]=ZF [1]=SF [2]=OF
module y86_execute
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [63:0] valA,
  input  logic [63:0] valB,
  input  logic [63:0] valC,
  output logic [63:0] valE,
  output logic        cnd,
  output logic [2:0]  flags
);

  logic [63:0] alu_a_s;
  logic [63:0] alu_b_s;
  logic [3:0]  alu_fun_s;
  logic [63:0] alu_res_s;
  logic [2:0]  alu_cc_s;
  logic        vale_en_s;
  logic        set_cc_s;
  logic        cond_s;
  logic        cnd_s;
  logic [2:0]  cc_r;

  // Operand and function selection by icode; vale_en_s gates valE to zero
  always_comb begin
    alu_a_s   = 64'd0;
    alu_b_s   = 64'd0;
    alu_fun_s = ALU_ADD;
    vale_en_s = 1'b0;
    case (icode)
      I_CMOVXX: begin
        alu_a_s   = valA;
        vale_en_s = 1'b1;
      end
      I_IRMOVQ: begin
        alu_a_s   = valC;
        vale_en_s = 1'b1;
      end
      I_RMMOVQ, I_MRMOVQ: begin
        alu_a_s   = valC;
        alu_b_s   = valB;
        vale_en_s = 1'b1;
      end
      I_OPQ: begin
        alu_a_s   = valA;
        alu_b_s   = valB;
        alu_fun_s = ifun;
        vale_en_s = (ifun <= ALU_XOR);
      end
      I_CALL, I_PUSHQ: begin
        alu_a_s   = 64'd8;
        alu_b_s   = valB;
        alu_fun_s = ALU_SUB;
        vale_en_s = 1'b1;
      end
      I_RET, I_POPQ: begin
        alu_a_s   = 64'd8;
        alu_b_s   = valB;
        vale_en_s = 1'b1;
      end
      default: begin
        vale_en_s = 1'b0;
      end
    endcase
  end

  y86_alu u_alu (
    .aluA   (alu_a_s),
    .aluB   (alu_b_s),
    .alufun (alu_fun_s),
    .result (alu_res_s),
    .cc_new (alu_cc_s)
  );

  // Final valE: halt/nop/jXX, undefined OPq functions and C..F give 0
  always_comb begin
    if (vale_en_s) begin
      valE = alu_res_s;
    end else begin
      valE = 64'd0;
    end
  end

  assign set_cc_s = (icode == I_OPQ) && (ifun <= ALU_XOR);

  // CC register: loads only on a valid OPq
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc_r <= CC_RESET;
    end else if (set_cc_s) begin
      cc_r <= alu_cc_s;
    end else begin
      cc_r <= cc_r;
    end
  end

  // Condition evaluation from the registered flags (pre-update in an OPq cycle)
  always_comb begin
    cond_s = 1'b0;
    case (ifun)
      C_ALWAYS: cond_s = 1'b1;
      C_LE:     cond_s = (cc_r[1] ^ cc_r[2]) | cc_r[0];
      C_L:      cond_s = cc_r[1] ^ cc_r[2];
      C_E:      cond_s = cc_r[0];
      C_NE:     cond_s = ~cc_r[0];
      C_GE:     cond_s = ~(cc_r[1] ^ cc_r[2]);
      C_G:      cond_s = ~(cc_r[1] ^ cc_r[2]) & ~cc_r[0];
      default:  cond_s = 1'b0;
    endcase
  end

  // cnd is only meaningful for cmovXX and jXX
  always_comb begin
    if ((icode == I_CMOVXX) || (icode == I_JXX)) begin
      cnd_s = cond_s;
    end else begin
      cnd_s = 1'b0;
    end
  end

  assign cnd   = cnd_s;
  assign flags = cc_r;

endmodule

// File: tb/tb_y86_execute.sv
// tb_y86_execute: directed bench for y86_execute with a behavioural
// reference model checked on every falling edge, plus literal expectations.
module tb_y86_execute;

  logic        clk;
  logic        rst;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [63:0] valC;
  logic [63:0] valE;
  logic        cnd;
  logic [2:0]  flags;

  int checks;
  int errors;
  logic started;
  logic [2:0] m_cc; // model CC, {OF,SF,ZF}

  y86_execute dut (
    .clk   (clk),
    .rst   (rst),
    .icode (icode),
    .ifun  (ifun),
    .valA  (valA),
    .valB  (valB),
    .valC  (valC),
    .valE  (valE),
    .cnd   (cnd),
    .flags (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference valE straight from the instruction semantics
  function automatic logic [63:0] m_vale(input logic [3:0] ic, input logic [3:0] fn,
                                         input logic [63:0] a, input logic [63:0] b,
                                         input logic [63:0] c);
    case (ic)
      4'h2: return a;
      4'h3: return c;
      4'h4, 4'h5: return b + c;
      4'h6: begin
        case (fn)
          4'h0: return b + a;
          4'h1: return b - a;
          4'h2: return b & a;
          4'h3: return b ^ a;
          default: return 64'd0;
        endcase
      end
      4'h8, 4'hA: return b - 64'd8;
      4'h9, 4'hB: return b + 64'd8;
      default: return 64'd0;
    endcase
  endfunction

  // Reference flags: overflow judged by a 65-bit signed result leaving 64-bit range
  function automatic logic [2:0] m_flags(input logic [3:0] fn, input logic [63:0] a,
                                         input logic [63:0] b);
    logic [63:0] r;
    logic [64:0] w;
    logic of;
    r  = m_vale(4'h6, fn, a, b, 64'd0);
    of = 1'b0;
    if (fn == 4'h0) begin
      w  = {b[63], b} + {a[63], a};
      of = w[64] ^ w[63];
    end else if (fn == 4'h1) begin
      w  = {b[63], b} - {a[63], a};
      of = w[64] ^ w[63];
    end
    return {of, r[63], (r == 64'd0)};
  endfunction

  function automatic logic m_cnd(input logic [3:0] ic, input logic [3:0] fn,
                                 input logic [2:0] cc);
    logic zf, sf, of;
    {of, sf, zf} = cc;
    if (ic != 4'h2 && ic != 4'h7) return 1'b0;
    case (fn)
      4'h0: return 1'b1;
      4'h1: return (sf != of) || zf;
      4'h2: return sf != of;
      4'h3: return zf;
      4'h4: return !zf;
      4'h5: return sf == of;
      4'h6: return (sf == of) && !zf;
      default: return 1'b0;
    endcase
  endfunction

  // Model CC register
  always @(posedge clk or posedge rst) begin
    if (rst) m_cc <= 3'b001;
    else if (icode == 4'h6 && ifun <= 4'h3) m_cc <= m_flags(ifun, valA, valB);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Compare process: DUT vs model on every falling edge
  always @(negedge clk) begin
    if (started) begin
      chk("model_valE", valE, m_vale(icode, ifun, valA, valB, valC));
      chk("model_cnd", {63'd0, cnd}, {63'd0, m_cnd(icode, ifun, m_cc)});
      chk("model_flags", {61'd0, flags}, {61'd0, m_cc});
    end
  end

  task automatic step(input logic [3:0] ic, input logic [3:0] fn,
                      input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    @(posedge clk);
    #2;
    icode = ic; ifun = fn; valA = a; valB = b; valC = c;
    @(negedge clk);
    #1;
  endtask

  initial begin
    checks = 0; errors = 0; started = 1'b0;
    rst = 1'b1;
    icode = 4'h1; ifun = 4'h0; valA = 64'd0; valB = 64'd0; valC = 64'd0;
    #1 started = 1'b1;

    // Reset state
    step(4'h1, 4'h0, 64'd0, 64'd0, 64'd0);
    chk("reset_flags", {61'd0, flags}, 64'd1);
    step(4'h7, 4'h3, 64'd0, 64'd0, 64'd0);
    chk("reset_je", {63'd0, cnd}, 64'd1);
    step(4'h7, 4'h4, 64'd0, 64'd0, 64'd0);
    chk("reset_jne", {63'd0, cnd}, 64'd0);
    @(posedge clk); #2 rst = 1'b0;

    // Moves and address arithmetic
    step(4'h2, 4'h0, 64'd6, 64'd99, 64'd77);
    chk("rrmovq_valE", valE, 64'd6);
    chk("rrmovq_cnd", {63'd0, cnd}, 64'd1);
    step(4'h3, 4'h0, 64'd1, 64'd2, 64'h7878);
    chk("irmovq_valE", valE, 64'h7878);
    step(4'h4, 4'h0, 64'd0, 64'h45, 64'h11);
    chk("rmmovq_valE", valE, 64'h56);
    step(4'h5, 4'h0, 64'd0, 64'd4, 64'd1);
    chk("mrmovq_valE", valE, 64'd5);

    // OPq add then jg
    step(4'h6, 4'h0, 64'h45, 64'h45, 64'd0);
    chk("add_valE", valE, 64'h8A);
    step(4'h7, 4'h6, 64'd0, 64'd0, 64'd0);
    chk("add_flags", {61'd0, flags}, 64'd0);
    chk("add_jg", {63'd0, cnd}, 64'd1);
    chk("jxx_valE", valE, 64'd0);

    // OPq sub, negative result, then jl
    step(4'h6, 4'h1, 64'h45, 64'hFFFF_FFFF_FFFF_FFBB, 64'd0);
    chk("subneg_valE", valE, 64'hFFFF_FFFF_FFFF_FF76);
    step(4'h7, 4'h2, 64'd0, 64'd0, 64'd0);
    chk("subneg_flags", {61'd0, flags}, 64'd2);
    chk("subneg_jl", {63'd0, cnd}, 64'd1);

    // OPq sub, positive result, then cmovle (false)
    step(4'h6, 4'h1, 64'hFFFF_FFFF_FFFF_FFFB, 64'h45, 64'd0);
    chk("subpos_valE", valE, 64'h4A);
    step(4'h2, 4'h1, 64'd3, 64'd0, 64'd0);
    chk("subpos_flags", {61'd0, flags}, 64'd0);
    chk("subpos_cmovle", {63'd0, cnd}, 64'd0);

    // xor to zero, then je and an undefined condition
    step(4'h6, 4'h3, 64'd5, 64'd5, 64'd0);
    chk("xor_valE", valE, 64'd0);
    step(4'h7, 4'h3, 64'd0, 64'd0, 64'd0);
    chk("xor_flags", {61'd0, flags}, 64'd1);
    chk("xor_je", {63'd0, cnd}, 64'd1);
    step(4'h7, 4'h7, 64'd0, 64'd0, 64'd0);
    chk("jxx_ifun7", {63'd0, cnd}, 64'd0);

    // Overflowing add, then jge
    step(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
    chk("ovf_valE", valE, 64'h8000_0000_0000_0000);
    step(4'h7, 4'h5, 64'd0, 64'd0, 64'd0);
    chk("ovf_flags", {61'd0, flags}, 64'd6);
    chk("ovf_jge", {63'd0, cnd}, 64'd1);

    // Undefined OPq function: valE 0, CC held
    step(4'h6, 4'h4, 64'd3, 64'd3, 64'd0);
    chk("opq4_valE", valE, 64'd0);
    step(4'h1, 4'h0, 64'd0, 64'd0, 64'd0);
    chk("opq4_flags_held", {61'd0, flags}, 64'd6);

    // Stack arithmetic and zero icodes
    step(4'h8, 4'h0, 64'd0, 64'h100, 64'd0);
    chk("call_valE", valE, 64'hF8);
    step(4'hA, 4'h0, 64'd0, 64'h100, 64'd0);
    chk("push_valE", valE, 64'hF8);
    step(4'h9, 4'h0, 64'd0, 64'h100, 64'd0);
    chk("ret_valE", valE, 64'h108);
    step(4'hB, 4'h0, 64'd0, 64'h100, 64'd0);
    chk("pop_valE", valE, 64'h108);
    step(4'hC, 4'h0, 64'd7, 64'd8, 64'd9);
    chk("icodeC_valE", valE, 64'd0);
    step(4'h0, 4'h0, 64'd7, 64'd8, 64'd9);
    chk("halt_valE", valE, 64'd0);

    // Asynchronous reset mid-cycle clears CC without a clock edge
    step(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
    @(posedge clk); #2;
    icode = 4'h1;
    chk("pre_async_flags", {61'd0, flags}, 64'd6);
    rst = 1'b1;
    #1;
    chk("async_rst_flags", {61'd0, flags}, 64'd1);
    @(posedge clk); #2 rst = 1'b0;
    step(4'h3, 4'h0, 64'd0, 64'd0, 64'h1234);
    chk("post_rst_valE", valE, 64'h1234);

    @(posedge clk);
    started = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
